// File: rtl/branch_predict_ctrl.sv
// Direct-mapped 2-bit saturating-counter branch predictor with misprediction
// flush/redirect generation and branch statistics.
module branch_predict_ctrl #(
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic [31:0]       ex_pc,
  input  logic              ex_pred_taken,
  input  logic              ex_taken,
  input  logic [31:0]       ex_target,
  output logic              flush,
  output logic [31:0]       redirect_pc,
  output logic              ready,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              r_state, w_next_state;
  logic [IDX_BITS-1:0] r_init_idx;
  logic [1:0]          r_table [ENTRIES];
  logic                r_flush;
  logic [31:0]         r_redirect;
  logic [STAT_W-1:0]   r_branches, r_mispredicts;

  logic [IDX_BITS-1:0] w_if_idx, w_ex_idx;
  logic                w_run, w_accept, w_mispredict;
  logic [1:0]          w_ctr, w_ctr_next;
  logic [31:0]         w_fallthru;
  logic                w_unused;

  assign w_if_idx     = if_pc[IDX_BITS+1:2];
  assign w_ex_idx     = ex_pc[IDX_BITS+1:2];
  assign w_run        = (r_state == ST_RUN);
  // A resolution arriving during the flush cycle is from the squashed path.
  assign w_accept     = w_run && ex_valid && !r_flush;
  assign w_mispredict = (ex_taken != ex_pred_taken);
  assign w_ctr        = r_table[w_ex_idx];
  assign w_fallthru   = {ex_pc[31:2], 2'b00} + 32'd4;
  assign w_unused     = ^{if_pc[31:IDX_BITS+2], if_pc[1:0], ex_pc[1:0]};

  assign ready            = w_run && !rst;
  assign if_pred_taken    = ready && r_table[w_if_idx][1];
  assign flush            = r_flush;
  assign redirect_pc      = r_redirect;
  assign stat_branches    = r_branches;
  assign stat_mispredicts = r_mispredicts;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT: if (&r_init_idx) w_next_state = ST_RUN;
      ST_RUN:  w_next_state = ST_RUN;
      default: w_next_state = ST_INIT;
    endcase
  end

  always_comb begin
    w_ctr_next = w_ctr;
    if (ex_taken && (w_ctr != 2'b11))       w_ctr_next = w_ctr + 2'd1;
    else if (!ex_taken && (w_ctr != 2'b00)) w_ctr_next = w_ctr - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_INIT;
      r_init_idx    <= '0;
      r_flush       <= 1'b0;
      r_redirect    <= '0;
      r_branches    <= '0;
      r_mispredicts <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_INIT) r_init_idx <= r_init_idx + 1'b1;
      r_flush <= w_accept && w_mispredict;
      if (w_accept && w_mispredict) r_redirect <= ex_taken ? ex_target : w_fallthru;
      if (w_accept && (r_branches != '1)) r_branches <= r_branches + STAT_W'(1);
      if (w_accept && w_mispredict && (r_mispredicts != '1))
        r_mispredicts <= r_mispredicts + STAT_W'(1);
    end
  end

  // The table has no reset; INIT rewrites every entry before predictions are enabled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_INIT) r_table[r_init_idx] <= 2'b01;
      else if (w_accept)      r_table[w_ex_idx]   <= w_ctr_next;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Randomised and directed bench for branch_predict_ctrl against a behavioural model.
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        ready;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int n_run  = 0;
  int n_fail = 0;

  // Behavioural model: counter values as integers 0..3, INIT as a countdown.
  int          m_tbl [16];
  int          m_init_left = 16;
  bit          m_flush = 0;
  logic [31:0] m_redir = '0;
  longint      m_br = 0;
  longint      m_mp = 0;

  always #5 clk = ~clk;

  branch_predict_ctrl #(.IDX_BITS(4), .STAT_W(32)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .ex_taken(ex_taken), .ex_target(ex_target), .flush(flush),
    .redirect_pc(redirect_pc), .ready(ready), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  function automatic int idx_of(logic [31:0] pc);
    return (pc / 4) % 16;
  endfunction

  function automatic bit m_ready();
    return (m_init_left == 0) && !rst;
  endfunction

  function automatic bit m_pred(logic [31:0] pc);
    return m_ready() && (m_tbl[idx_of(pc)] >= 2);
  endfunction

  task automatic model_step();
    int i;
    bit mis;
    if (rst) begin
      m_init_left = 16; m_flush = 0; m_redir = '0; m_br = 0; m_mp = 0;
    end else if (m_init_left > 0) begin
      m_tbl[16 - m_init_left] = 1;
      m_init_left--;
      m_flush = 0;
    end else if (ex_valid && !m_flush) begin
      i   = idx_of(ex_pc);
      mis = (ex_taken != ex_pred_taken);
      if (ex_taken) m_tbl[i] = (m_tbl[i] < 3) ? m_tbl[i] + 1 : 3;
      else          m_tbl[i] = (m_tbl[i] > 0) ? m_tbl[i] - 1 : 0;
      if (m_br < 64'hFFFF_FFFF) m_br++;
      if (mis && m_mp < 64'hFFFF_FFFF) m_mp++;
      m_flush = mis;
      if (mis) m_redir = ex_taken ? ex_target : ((ex_pc & 32'hFFFF_FFFC) + 32'd4);
    end else begin
      m_flush = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_run++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b expected 0", ready); end
    n_run++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %0b expected 0", flush); end
    n_run++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect: got %0h expected 0", redirect_pc); end
    n_run++; if (stat_branches !== 32'h0 || stat_mispredicts !== 32'h0) begin
      n_fail++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_branches, stat_mispredicts);
    end
  endtask

  task automatic test_init();
    rst = 1'b0;
    ex_valid = 1'b1; ex_pc = 32'h80; ex_pred_taken = 1'b0; ex_taken = 1'b1; ex_target = 32'h1234;
    for (int i = 0; i < 16; i++) begin
      if_pc = $urandom;
      #1;
      n_run++; if (ready !== 1'b0) begin n_fail++; $display("FAIL init_ready[%0d]: got %0b expected 0", i, ready); end
      n_run++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL init_pred[%0d]: got %0b expected 0", i, if_pred_taken); end
      n_run++; if (flush !== 1'b0 || stat_branches !== 32'h0 || stat_mispredicts !== 32'h0) begin
        n_fail++; $display("FAIL init_ignore[%0d]: got flush=%0b br=%0d mp=%0d expected 0/0/0", i, flush, stat_branches, stat_mispredicts);
      end
      tick();
    end
    ex_valid = 1'b0;
    #1;
    n_run++; if (ready !== 1'b1) begin n_fail++; $display("FAIL init_done_ready: got %0b expected 1", ready); end
    n_run++; if (flush !== 1'b0 || stat_branches !== 32'h0) begin
      n_fail++; $display("FAIL init_done_quiet: got flush=%0b br=%0d expected 0/0", flush, stat_branches);
    end
  endtask

  task automatic test_taken_mispredict();
    ex_valid = 1'b1; ex_pc = 32'h80; ex_pred_taken = 1'b0; ex_taken = 1'b1; ex_target = 32'h200;
    tick();
    ex_valid = 1'b0;
    n_run++; if (flush !== 1'b1) begin n_fail++; $display("FAIL tmis_flush: got %0b expected 1", flush); end
    n_run++; if (redirect_pc !== 32'h200) begin n_fail++; $display("FAIL tmis_redirect: got %0h expected 200", redirect_pc); end
    n_run++; if (stat_branches !== 32'd1 || stat_mispredicts !== 32'd1) begin
      n_fail++; $display("FAIL tmis_stats: got %0d/%0d expected 1/1", stat_branches, stat_mispredicts);
    end
    tick();
    n_run++; if (flush !== 1'b0) begin n_fail++; $display("FAIL tmis_pulse: got %0b expected 0", flush); end
    n_run++; if (redirect_pc !== 32'h200) begin n_fail++; $display("FAIL tmis_hold: got %0h expected 200", redirect_pc); end
  endtask

  task automatic test_training();
    for (int k = 0; k < 2; k++) begin
      ex_valid = 1'b1; ex_pc = 32'h100; ex_pred_taken = 1'b0; ex_taken = 1'b1; ex_target = 32'h300;
      tick();
      ex_valid = 1'b0;
      n_run++; if (flush !== 1'b1 || redirect_pc !== 32'h300) begin
        n_fail++; $display("FAIL train_flush[%0d]: got %0b/%0h expected 1/300", k, flush, redirect_pc);
      end
      tick();
    end
    if_pc = 32'h100; #1;
    n_run++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL train_pred_100: got %0b expected 1", if_pred_taken); end
    if_pc = 32'h140; #1;
    n_run++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL train_alias_140: got %0b expected 1", if_pred_taken); end
    if_pc = 32'h104; #1;
    n_run++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL train_pred_104: got %0b expected 0", if_pred_taken); end
    for (int k = 0; k < 3; k++) begin
      ex_valid = 1'b1; ex_pc = 32'h100; ex_taken = 1'b0; ex_pred_taken = m_pred(32'h100);
      tick();
      ex_valid = 1'b0;
      tick();
    end
    if_pc = 32'h100; #1;
    n_run++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL train_untrain: got %0b expected 0", if_pred_taken); end
  endtask

  task automatic test_wrap();
    ex_valid = 1'b1; ex_pc = 32'hFFFF_FFFC; ex_pred_taken = 1'b1; ex_taken = 1'b0; ex_target = 32'h40;
    tick();
    ex_valid = 1'b0;
    n_run++; if (flush !== 1'b1 || redirect_pc !== 32'h0) begin
      n_fail++; $display("FAIL wrap_redirect: got %0b/%0h expected 1/0", flush, redirect_pc);
    end
    tick();
  endtask

  task automatic test_wrong_path();
    logic [31:0] br, mp;
    ex_valid = 1'b1; ex_pc = 32'h40; ex_pred_taken = 1'b0; ex_taken = 1'b1; ex_target = 32'h500;
    tick();
    n_run++; if (flush !== 1'b1) begin n_fail++; $display("FAIL wp_first_flush: got %0b expected 1", flush); end
    br = stat_branches; mp = stat_mispredicts;
    ex_pc = 32'h44; ex_target = 32'h600; if_pc = 32'h44;
    tick();
    ex_valid = 1'b0;
    n_run++; if (flush !== 1'b0 || redirect_pc !== 32'h500) begin
      n_fail++; $display("FAIL wp_second_flush: got %0b/%0h expected 0/500", flush, redirect_pc);
    end
    n_run++; if (stat_branches !== br || stat_mispredicts !== mp) begin
      n_fail++; $display("FAIL wp_stats: got %0d/%0d expected %0d/%0d", stat_branches, stat_mispredicts, br, mp);
    end
    n_run++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL wp_entry: got %0b expected 0", if_pred_taken); end
    if_pc = 32'h48;
    ex_valid = 1'b1; ex_pc = 32'h48; ex_pred_taken = 1'b0; ex_taken = 1'b1; ex_target = 32'h700;
    #1;
    n_run++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL rbw_old: got %0b expected 0", if_pred_taken); end
    tick();
    ex_valid = 1'b0;
    n_run++; if (if_pred_taken !== 1'b1 || flush !== 1'b1) begin
      n_fail++; $display("FAIL rbw_new: got pred=%0b flush=%0b expected 1/1", if_pred_taken, flush);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst       = (i < 370) && ($urandom_range(0, 149) == 0);
      ex_valid  = $urandom_range(0, 1);
      ex_pc     = $urandom;
      ex_taken  = $urandom_range(0, 1);
      ex_pred_taken = ($urandom_range(0, 9) < 7) ? m_pred(ex_pc) : 1'($urandom_range(0, 1));
      ex_target = $urandom;
      if_pc     = ($urandom_range(0, 1) == 1) ? ex_pc : $urandom;
      #1;
      n_run++; if (if_pred_taken !== m_pred(if_pc) || ready !== m_ready()) begin
        n_fail++; $display("FAIL rand_pred[%0d]: got pred=%0b ready=%0b expected %0b/%0b", i, if_pred_taken, ready, m_pred(if_pc), m_ready());
      end
      tick();
      n_run++; if (flush !== m_flush || redirect_pc !== m_redir) begin
        n_fail++; $display("FAIL rand_flush[%0d]: got %0b/%0h expected %0b/%0h", i, flush, redirect_pc, m_flush, m_redir);
      end
      n_run++; if (stat_branches !== m_br[31:0] || stat_mispredicts !== m_mp[31:0]) begin
        n_fail++; $display("FAIL rand_stats[%0d]: got %0d/%0d expected %0d/%0d", i, stat_branches, stat_mispredicts, m_br, m_mp);
      end
    end
    rst = 1'b0; ex_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midrun();
    for (int k = 0; k < 2; k++) begin
      ex_valid = 1'b1; ex_pc = 32'h100; ex_taken = 1'b1; ex_pred_taken = m_pred(32'h100);
      tick();
      ex_valid = 1'b0;
      tick();
    end
    ex_valid = 1'b1; ex_pc = 32'h100; ex_pred_taken = 1'b1; ex_taken = 1'b0;
    tick();
    ex_valid = 1'b0;
    n_run++; if (flush !== 1'b1) begin n_fail++; $display("FAIL mid_pending_flush: got %0b expected 1", flush); end
    rst = 1'b1;
    tick();
    n_run++; if (flush !== 1'b0 || ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_outputs: got flush=%0b ready=%0b expected 0/0", flush, ready);
    end
    n_run++; if (stat_branches !== 32'h0 || stat_mispredicts !== 32'h0) begin
      n_fail++; $display("FAIL mid_rst_stats: got %0d/%0d expected 0/0", stat_branches, stat_mispredicts);
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_run++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_init_ready[%0d]: got %0b expected 0", i, ready); end
      tick();
    end
    if_pc = 32'h100; #1;
    n_run++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %0b expected 1", ready); end
    n_run++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL mid_table_reinit: got %0b expected 0", if_pred_taken); end
  endtask

  initial begin
    rst = 1'b1; if_pc = '0; ex_valid = 1'b0; ex_pc = '0;
    ex_pred_taken = 1'b0; ex_taken = 1'b0; ex_target = '0;
    test_reset();
    test_init();
    test_taken_mispredict();
    test_training();
    test_wrap();
    test_wrong_path();
    test_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Branch prediction and resolution controller for the pipelined RV32I core.
- Holds a direct-mapped table of 2-bit saturating counters. Supplies a taken/not-taken prediction to fetch.
- Takes the resolved outcome from the execute-stage branch comparator and trains the table.
- On a misprediction it issues a one-cycle flush with the corrected PC. It also keeps branch and mispredict statistics.

Parameters:
- IDX_BITS, 4, log2 of table entries; index = pc[IDX_BITS+1:2].
- STAT_W, 32, width of statistic counters.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_pc  in  32  fetch-stage PC to predict.
- if_pred_taken  out  1  prediction for if_pc (combinational table read).
- ex_valid  in  1  execute stage holds a resolved conditional branch this cycle.
- ex_pc  in  32  PC of the resolving branch.
- ex_pred_taken  in  1  prediction that was carried down the pipe with this branch.
- ex_taken  in  1  actual outcome from the branch comparator.
- ex_target  in  32  computed branch target.
- flush  out  1  one-cycle pulse: squash younger instructions.
- redirect_pc  out  32  corrected fetch PC, valid while flush=1.
- ready  out  1  table initialised, predictor active.
- stat_branches  out  STAT_W  resolved branches counted.
- stat_mispredicts  out  STAT_W  mispredictions counted.

Behaviour:
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = bit[1]. Init value 01.
- FSM has two states: INIT and RUN.
- rst=1 (any state, including mid-operation):
  - next state INIT, init index <= 0.
  - flush <= 0, redirect_pc <= 0, stats <= 0.
  - ready = 0.
- INIT:
  - Each cycle with rst=0, write 01 to entry[init index] and increment the index.
  - After writing the last entry (2^IDX_BITS - 1) -> RUN.
  - INIT therefore lasts exactly 2^IDX_BITS cycles after rst falls.
  - In INIT: ready=0, if_pred_taken=0, ex_valid ignored (no update, no stats, no flush).
- RUN:
  - ready=1. if_pred_taken = entry[if_pc idx][1].
  - The update is accepted when ex_valid=1 and flush=0.
  - Counter update on an accepted resolution:
    - ex_taken=1: increment, saturating at 11.
    - ex_taken=0: decrement, saturating at 00.
  - Mispredict: an accepted resolution with ex_taken != ex_pred_taken. Next cycle:
    - flush=1.
    - redirect_pc = ex_taken ? ex_target : ex_pc+4. ex_pc+4 is modulo 2^32, so 0xFFFFFFFC -> 0x00000000.
  - Correct prediction: flush=0 next cycle.
  - flush is a single-cycle pulse. redirect_pc holds its last value when flush=0.
- Resolution while flush=1: it is a wrong-path branch and is fully ignored (no table update, no stats, no flush).
- Same-cycle lookup and update of the same index: if_pred_taken returns the pre-update value (read-before-write).
- Statistics:
  - stat_branches increments on every accepted resolution.
  - stat_mispredicts increments on every accepted mispredict.
  - Both saturate at all-ones.
- Aliasing: distinct PCs with equal pc[IDX_BITS+1:2] share an entry. This is intended.
- ex_pc[1:0] is ignored.

Test Plan:
- Init with IDX_BITS=4: pulse rst for 2 cycles, release -> ready=0 for exactly 16 cycles then 1. if_pred_taken=0 for every if_pc. ex_valid=1 during INIT produces no flush and no stat change.
- Training:
  - Two accepted resolutions at ex_pc=0x100 with ex_taken=1 and ex_pred_taken=0.
  - First one yields flush=1, redirect_pc=ex_target. The second one is accepted only in a cycle where flush=0.
  - Result: entry 01->10->11. if_pc=0x100 and aliased 0x140 predict 1; 0x104 predicts 0.
  - Three not-taken resolutions then return the prediction to 0.
- Taken mispredict: ex_pc=0x80, ex_pred_taken=0, ex_taken=1, ex_target=0x200 -> next cycle flush=1, redirect_pc=0x200, stat_mispredicts=1, stat_branches=1. Following cycle flush=0.
- Not-taken mispredict with wrap: ex_pc=0xFFFFFFFC, ex_pred_taken=1, ex_taken=0 -> flush=1, redirect_pc=0x00000000.
- Wrong-path suppression: a mispredict is followed immediately by another mispredicting ex_valid during the flush cycle -> no second flush, stats unchanged, entry unchanged. Same-cycle lookup/update of one index returns the old prediction.
- Reset mid-run: after training and with a pending flush, assert rst for 1 cycle -> flush=0, stats=0, ready=0. INIT reruns for 16 cycles and the table returns to 01 everywhere (if_pc=0x100 predicts 0).
